// File: rtl/cla_nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial carry-look-ahead adder.
//   state_t   : controller states (IDLE, RUN, DONE)
//   NIB_W     : width of the shared adder slice in bits
//   calc_nib  : number of slice passes needed for a given operand width
package cla_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic int unsigned calc_nib(input int unsigned width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/cla_nibble_serial_adder_cla4_slice.sv
// 4-bit carry-look-ahead adder slice, purely combinational.
// Ports:
//   i_a, i_b : nibble operands
//   i_c      : carry into bit 0
//   o_s      : nibble sum
//   o_c3     : carry into bit 3 (used for signed overflow on the top nibble)
//   o_co     : carry out of bit 3
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIB_W-1:0] i_a,
  input  logic [NIB_W-1:0] i_b,
  input  logic             i_c,
  output logic [NIB_W-1:0] o_s,
  output logic             o_c3,
  output logic             o_co
);

  logic [NIB_W-1:0] w_p;
  logic [NIB_W-1:0] w_g;
  logic             w_c1;
  logic             w_c2;
  logic             w_c3;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  // Every carry is a flat sum of products of generate/propagate terms, so no
  // carry ripples through a previous one.
  assign w_c1 = w_g[0] | (w_p[0] & i_c);
  assign w_c2 = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
  assign w_c3 = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
              | (w_p[2] & w_p[1] & w_p[0] & i_c);
  assign o_co = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
              | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
              | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

  assign o_s  = w_p ^ {w_c3, w_c2, w_c1, i_c};
  assign o_c3 = w_c3;

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that reuses one 4-bit CLA slice per nibble,
// least-significant nibble first, with the inter-nibble carry held in a register.
// Ports:
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, cin sampled on accept)
//   out_valid/out_ready : result handshake (sum, cout, ovf held while waiting)
//   sum                 : (a + b + cin) mod 2^WIDTH
//   cout                : carry out of bit WIDTH-1
//   ovf                 : signed overflow
//   busy                : high while nibbles are being processed
module cla_nibble_serial_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB   = calc_nib(WIDTH);
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
    $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [IDX_W-1:0] r_idx;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic [NIB_W-1:0] w_a_nib;
  logic [NIB_W-1:0] w_b_nib;
  logic [NIB_W-1:0] w_s;
  logic             w_c3;
  logic             w_co;

  assign w_last  = (r_idx == LAST_IDX);
  assign w_a_nib = r_a[{r_idx, 2'b00} +: NIB_W];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: NIB_W];

  cla4_slice u_slice (
    .i_a  (w_a_nib),
    .i_b  (w_b_nib),
    .i_c  (r_carry),
    .o_s  (w_s),
    .o_c3 (w_c3),
    .o_co (w_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // In DONE, a new pair can be taken on the very edge the current result
  // retires, so in_ready follows out_ready there.
  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    w_load   = 1'b0;
    w_step   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load = 1'b1;
          w_next = RUN;
        end
      end
      RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            w_load = 1'b1;
            w_next = RUN;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_sum   <= '0;
      r_idx   <= '0;
    end else if (w_step) begin
      r_sum[{r_idx, 2'b00} +: NIB_W] <= w_s;
      r_carry <= w_co;
      // Wrap explicitly so a non-power-of-two nibble count never walks
      // past the last nibble.
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_co;
        r_ovf  <= w_c3 ^ w_co;
      end
    end
  end

  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == RUN);

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
module tb_cla_nibble_serial_adder;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  cla_nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer addition; overflow when both operands share a
  // sign and the result's sign differs.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] full;
    logic       v;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v    = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {v, full};
  endfunction

  // Presents a pair and returns just after the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int unsigned cyc;
    @(negedge clk);
    a = x; b = y; cin = c; in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Called just after an accepting edge; waits for the result, applies
  // 'stall' cycles of backpressure, then retires it.
  task automatic collect(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                         input int unsigned stall, input string tag);
    logic [W+1:0] e;
    int unsigned  lat;
    e = model(x, y, c);
    out_ready = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, lat, 32'd5);
    for (int unsigned i = 0; i < stall; i++) begin
      check({tag, "_hold_sum"}, 32'(sum), 32'(e[W-1:0]));
      check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
    end
    check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(e[W]));
    check({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic txn(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                     input int unsigned stall, input string tag);
    send(x, y, c);
    collect(x, y, c, stall, tag);
    @(negedge clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [W+1:0] e;
    logic [W-1:0] rx;
    logic [W-1:0] ry;
    logic         rc;
    int unsigned  lat;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    txn(16'h1234, 16'h0FFF, 1'b0, 0, "basic");
    txn(16'hFFFF, 16'h0001, 1'b0, 0, "ripple1");
    txn(16'h7FFF, 16'h0001, 1'b0, 0, "sovf1");
    txn(16'h8000, 16'h8000, 1'b0, 0, "sovf2");
    txn(16'hFFFF, 16'h0000, 1'b1, 0, "ripple2");

    // Backpressure with a new pair waiting, then back-to-back accept
    send(16'h1234, 16'h0FFF, 1'b0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check("bp_latency", lat, 32'd5);
    a = 16'h7FFF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_sum_held", 32'(sum), 32'h2233);
      @(negedge clk);
      check("bp_valid_held", 32'(out_valid), 32'd1);
    end
    check("bp_sum_final", 32'(sum), 32'h2233);
    out_ready = 1'b1;
    #1 check("bp_in_ready_comb", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 begin in_valid = 1'b0; out_ready = 1'b0; end
    collect(16'h7FFF, 16'h0001, 1'b0, 0, "b2b");

    // Reset in the middle of a run; previous result left cout=1
    send(16'hFFFF, 16'h0001, 1'b0);
    collect(16'hFFFF, 16'h0001, 1'b0, 0, "pre_rst");
    send(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mid_rst_no_valid", 32'(out_valid), 32'd0);
    end
    txn(16'h0005, 16'h0003, 1'b0, 0, "post_rst");

    // Random stream with random stalls
    for (int unsigned n = 0; n < 1000; n++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      send(rx, ry, rc);
      collect(rx, ry, rc, $urandom_range(0, 3), "rand");
    end

    // Sanity that the model agrees with the hand-computed basic result
    e = model(16'h1234, 16'h0FFF, 1'b0);
    check("model_basic", 32'(e[W-1:0]), 32'h2233);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule
